y_adaptive_binarize: RTL and testbench
======================================

// Module: y_adaptive_binarize
// PURPOSE
//  Consumes the Y stream from rgb2ycbcr and emits a binary image (0x00/0xFF) per pixel.
//  Threshold is frame-adaptive: at each frame end it becomes (min_Y + max_Y + 1) >> 1 of
//  that frame and is applied to the next frame. Output stream feeds bmp_for_videoStream or
//  morphology stages. Sync signals pass through with matched latency.
// PARAMETERS
//  THR_INIT     8'd128  threshold used from reset until the first qualifying frame end
//  MIN_CONTRAST 8'd16   if (max_Y - min_Y) < MIN_CONTRAST, threshold is not updated
//  INVERT       1'b0    1: output 0xFF for Y < thr, 0x00 otherwise
// PORTS
//  clk             in   1  system clock
//  rst_n           in   1  asynchronous reset, active low
//  per_img_vsync   in   1  frame sync, high for the whole active frame
//  per_img_herf    in   1  line reference, high during active line
//  per_img_valid   in   1  Y pixel valid
//  per_img_Y       in   8  luma from rgb2ycbcr
//  post_img_vsync  out  1  per_img_vsync delayed 2 clk
//  post_img_herf   out  1  per_img_herf delayed 2 clk
//  post_img_valid  out  1  per_img_valid delayed 2 clk
//  post_img_bin    out  8  0x00 or 0xFF
//  frame_thr       out  8  threshold currently applied
//  frame_min       out  8  min Y of last completed frame
//  frame_max       out  8  max Y of last completed frame
// BEHAVIOUR
//  - Reset (async): all post_* = 0, post_img_bin = 0, frame_thr = THR_INIT,
//    frame_min = 0, frame_max = 0, run_min = 8'hFF, run_max = 8'h00, state = IDLE.
//  - Latency: per_img_* at cycle N -> post_img_* at N+2. S1 registers Y>=frame_thr compare;
//    S2 registers bin (INVERT applied). Sync and valid delayed by identical 2-stage shift.
//  - post_img_bin = 0 whenever post_img_valid = 0.
//  - FSM: IDLE -> ACTIVE on vsync rising edge (vsync_d1=0, vsync=1): run_min<=FF, run_max<=00,
//    pix_seen<=0. ACTIVE: each per_img_valid updates run_min/run_max with that Y, pix_seen<=1.
//    ACTIVE -> UPDATE on vsync falling edge. UPDATE (1 clk): frame_min/max <= run_min/max;
//    if pix_seen && (run_max-run_min) >= MIN_CONTRAST then frame_thr <= ({1'b0,run_min}
//    + run_max + 1) >> 1 (9-bit sum, no overflow); else frame_thr holds. UPDATE -> IDLE.
//  - frame_thr changes only in UPDATE, so it is constant across every pixel of a frame.
//  - per_img_valid while vsync low: pixel still binarized/passed, excluded from statistics.
//  - vsync rising edge during UPDATE cycle: UPDATE completes, then FSM enters ACTIVE
//    directly with fresh run_min/max (edge latched, not lost).
//  - Frame with zero valid pixels: frame_min/max still latched (FF/00), threshold holds.
//  - rst_n low mid-frame: everything returns to reset values immediately; partial frame stats
//    discarded; next rising vsync starts a clean frame.
// CONFIGURATION
//  BIN_MANUAL_THR_EN defined: adds ports thr_sel (in 1) and thr_manual (in 8). When thr_sel=1
//  the compare uses thr_manual (sampled at vsync rising edge, held for the frame) and
//  frame_thr reports it; adaptive stats still accumulate and frame_min/max still update.
//  Not defined: ports absent, threshold is always adaptive.
// TESTING
//  1 Reset then frame of 4x4 Y ramp 0..15*16 -> frame_thr=128 during frame 1, post_img_bin
//    = 0xFF only for Y>=128; after frame end frame_min=0, frame_max=240, frame_thr=120.
//  2 Frame 2 same ramp -> pixels Y>=120 give 0xFF; post_* exactly 2 clk after per_*.
//  3 Flat frame Y=50 all pixels -> contrast 0 < 16, frame_thr unchanged; frame_min=max=50.
//  4 Frame Y in {10,200} -> frame_thr=105; INVERT=1 build -> Y=10 outputs 0xFF.
//  5 rst_n pulse low mid-frame 2 -> outputs 0 same cycle, frame_thr=128; next frame stats clean.
//  6 BIN_MANUAL_THR_EN, thr_sel=1, thr_manual=60, Y=59/60 -> 0x00/0xFF; toggle mid-frame ignored.

Source files
------------

// File: rtl/y_adaptive_binarize.sv
// rtl/y_adaptive_binarize.sv - frame-adaptive luma binarizer with 2-clk matched sync latency
//
// Converts a Y (luma) pixel stream into a binary image (0x00 / 0xFF). The
// threshold for each frame is (min_Y + max_Y + 1) >> 1 of the previous frame,
// provided that frame had enough contrast; otherwise the old threshold holds.
//
// Optional feature macro: BIN_MANUAL_THR_EN
//   When defined, adds thr_sel / thr_manual. With thr_sel=1 (sampled at the
//   vsync rising edge, held for the frame) the compare uses thr_manual and
//   frame_thr reports it. Adaptive statistics keep accumulating regardless.
//
// Parameters:
//   THR_INIT      threshold used from reset until the first qualifying frame end
//   MIN_CONTRAST  minimum (max_Y - min_Y) needed to update the threshold
//   INVERT        1: output 0xFF for Y < thr, 0x00 otherwise
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   per_img_vsync/herf/valid/Y      input frame sync, line ref, pixel valid, luma
//   thr_sel, thr_manual             manual threshold select/value (macro only)
//   post_img_vsync/herf/valid       input sync/valid delayed by 2 clk
//   post_img_bin                    0x00 / 0xFF result, 0 when post_img_valid=0
//   frame_thr                       threshold currently applied to the compare
//   frame_min, frame_max            min / max Y of the last completed frame

module y_adaptive_binarize #(
    parameter logic [7:0] THR_INIT     = 8'd128,
    parameter logic [7:0] MIN_CONTRAST = 8'd16,
    parameter bit         INVERT       = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       per_img_vsync,
    input  logic       per_img_herf,
    input  logic       per_img_valid,
    input  logic [7:0] per_img_Y,
`ifdef BIN_MANUAL_THR_EN
    input  logic       thr_sel,
    input  logic [7:0] thr_manual,
`endif
    output logic       post_img_vsync,
    output logic       post_img_herf,
    output logic       post_img_valid,
    output logic [7:0] post_img_bin,
    output logic [7:0] frame_thr,
    output logic [7:0] frame_min,
    output logic [7:0] frame_max
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        UPDATE = 2'd2
    } state_t;

    state_t     state_q, state_d;

    // Pipeline stage 1
    logic       s1_vsync, s1_herf, s1_valid, s1_ge;

    // Frame statistics
    logic [7:0] run_min, run_max;
    logic       pix_seen;
    logic [7:0] thr_adapt;
    logic [7:0] thr_apply;

    // Dedicated vsync edge register. It resets to 1 so that a vsync that is
    // already high when reset is released is not mistaken for a new frame:
    // after a mid-frame reset only the next genuine rising edge starts a frame.
    logic       vsync_q;
    logic       vsync_rise, vsync_fall, frame_start;

    logic [7:0] contrast;
    logic [8:0] mid_sum;

    assign vsync_rise  = per_img_vsync & ~vsync_q;
    assign vsync_fall  = ~per_img_vsync & vsync_q;
    // A rise can only legally occur outside ACTIVE; in UPDATE it is honoured
    // in the same cycle so back-to-back frames lose no edge.
    assign frame_start = vsync_rise & (state_q != ACTIVE);

    assign contrast = run_max - run_min;
    assign mid_sum  = {1'b0, run_min} + {1'b0, run_max} + 9'd1;

    //--------------------------------------------------------------------
    // Threshold selection
    //--------------------------------------------------------------------
`ifdef BIN_MANUAL_THR_EN
    logic       man_sel_q;
    logic [7:0] man_thr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            man_sel_q <= 1'b0;
            man_thr_q <= 8'h00;
        end else if (frame_start) begin
            man_sel_q <= thr_sel;
            man_thr_q <= thr_manual;
        end
    end

    assign thr_apply = man_sel_q ? man_thr_q : thr_adapt;
`else
    assign thr_apply = thr_adapt;
`endif

    assign frame_thr = thr_apply;

    //--------------------------------------------------------------------
    // FSM
    //--------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vsync_q <= 1'b1;
        end else begin
            state_q <= state_d;
            vsync_q <= per_img_vsync;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (vsync_rise) state_d = ACTIVE;
            ACTIVE:  if (vsync_fall) state_d = UPDATE;
            UPDATE:  state_d = vsync_rise ? ACTIVE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    //--------------------------------------------------------------------
    // Running statistics and end-of-frame latch
    //--------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_min   <= 8'hFF;
            run_max   <= 8'h00;
            pix_seen  <= 1'b0;
            frame_min <= 8'h00;
            frame_max <= 8'h00;
            thr_adapt <= THR_INIT;
        end else begin
            // UPDATE reads the old run_* values, so a frame start in the
            // same cycle can safely reinitialise them.
            if (state_q == UPDATE) begin
                frame_min <= run_min;
                frame_max <= run_max;
                if (pix_seen && (contrast >= MIN_CONTRAST)) begin
                    thr_adapt <= mid_sum[8:1];
                end
            end

            if (frame_start) begin
                // A pixel arriving on the very edge cycle belongs to the frame.
                run_min  <= per_img_valid ? per_img_Y : 8'hFF;
                run_max  <= per_img_valid ? per_img_Y : 8'h00;
                pix_seen <= per_img_valid;
            end else if ((state_q == ACTIVE) && per_img_valid && per_img_vsync) begin
                if (per_img_Y < run_min) run_min <= per_img_Y;
                if (per_img_Y > run_max) run_max <= per_img_Y;
                pix_seen <= 1'b1;
            end
        end
    end

    //--------------------------------------------------------------------
    // Two-stage pixel pipeline
    //--------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vsync       <= 1'b0;
            s1_herf        <= 1'b0;
            s1_valid       <= 1'b0;
            s1_ge          <= 1'b0;
            post_img_vsync <= 1'b0;
            post_img_herf  <= 1'b0;
            post_img_valid <= 1'b0;
            post_img_bin   <= 8'h00;
        end else begin
            s1_vsync       <= per_img_vsync;
            s1_herf        <= per_img_herf;
            s1_valid       <= per_img_valid;
            s1_ge          <= (per_img_Y >= thr_apply);
            post_img_vsync <= s1_vsync;
            post_img_herf  <= s1_herf;
            post_img_valid <= s1_valid;
            post_img_bin   <= s1_valid ? {8{s1_ge ^ INVERT}} : 8'h00;
        end
    end

endmodule

// File: tb/tb_y_adaptive_binarize.sv
// tb/tb_y_adaptive_binarize.sv - self-checking bench for y_adaptive_binarize

module tb_y_adaptive_binarize;

    localparam logic [7:0] THR_INIT = 8'd128;
    localparam int         MIN_CON  = 16;
    localparam bit         INV      = 1'b0;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       per_img_vsync, per_img_herf, per_img_valid;
    logic [7:0] per_img_Y;
    logic       thr_sel;
    logic [7:0] thr_manual;
    logic       post_img_vsync, post_img_herf, post_img_valid;
    logic [7:0] post_img_bin, frame_thr, frame_min, frame_max;

    always #5 clk = ~clk;

    y_adaptive_binarize #(
        .THR_INIT    (THR_INIT),
        .MIN_CONTRAST(8'(MIN_CON)),
        .INVERT      (INV)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .per_img_vsync (per_img_vsync),
        .per_img_herf  (per_img_herf),
        .per_img_valid (per_img_valid),
        .per_img_Y     (per_img_Y),
`ifdef BIN_MANUAL_THR_EN
        .thr_sel       (thr_sel),
        .thr_manual    (thr_manual),
`endif
        .post_img_vsync(post_img_vsync),
        .post_img_herf (post_img_herf),
        .post_img_valid(post_img_valid),
        .post_img_bin  (post_img_bin),
        .frame_thr     (frame_thr),
        .frame_min     (frame_min),
        .frame_max     (frame_max)
    );

    typedef struct {
        logic       vs;
        logic       hr;
        logic       va;
        logic [7:0] bin;
    } exp_t;

    int   checks = 0;
    int   errors = 0;

    // Reference model state
    logic [7:0] m_thr, m_min, m_max;
    logic       m_man_on;
    logic [7:0] m_man_val;
    exp_t       e1, e2;
    logic [7:0] y_seen[$];
    logic [7:0] pix_q[$];

    function automatic logic [7:0] applied_thr();
        return m_man_on ? m_man_val : m_thr;
    endfunction

    // One input cycle: drive, predict its output, and compare the output
    // due from two cycles earlier.
    task automatic drive_cycle(input logic vs, input logic hr, input logic va, input logic [7:0] y);
        exp_t cur;
        @(posedge clk);
        #1;
        per_img_vsync = vs;
        per_img_herf  = hr;
        per_img_valid = va;
        per_img_Y     = y;
        cur.vs  = vs;
        cur.hr  = hr;
        cur.va  = va;
        cur.bin = (va && ((y >= applied_thr()) != INV)) ? 8'hFF : 8'h00;
        if (vs && va) y_seen.push_back(y);
        @(negedge clk);
        checks++;
        if ({post_img_vsync, post_img_herf, post_img_valid, post_img_bin} !==
            {e2.vs, e2.hr, e2.va, e2.bin}) begin
            errors++;
            $display("FAIL stream t=%0t got vs%b hr%b va%b bin%h want vs%b hr%b va%b bin%h", $time,
                     post_img_vsync, post_img_herf, post_img_valid, post_img_bin,
                     e2.vs, e2.hr, e2.va, e2.bin);
        end
        e2 = e1;
        e1 = cur;
    endtask

    // Plays pix_q as one frame of lines 'w' wide, then 'gap' vsync-low cycles.
    task automatic play_frame(input int w, input bit bubbles, input int gap);
        int n = 0;
        int c;
`ifdef BIN_MANUAL_THR_EN
        m_man_on  = thr_sel;
        m_man_val = thr_manual;
`endif
        y_seen.delete();
        drive_cycle(1, 0, 0, 8'h00);
        drive_cycle(1, 0, 0, 8'h00);
        checks++;
        if (frame_thr !== applied_thr()) begin
            errors++;
            $display("FAIL thr_in_frame got %0d want %0d", frame_thr, applied_thr());
        end
        while (n < pix_q.size()) begin
            c = 0;
            while (c < w && n < pix_q.size()) begin
                if (bubbles && $urandom_range(0, 3) == 0) begin
                    drive_cycle(1, 1, 0, 8'($urandom));
                end else begin
                    drive_cycle(1, 1, 1, pix_q[n]);
                    n++;
                    c++;
                end
            end
            drive_cycle(1, 0, 0, 8'h00);
        end
        drive_cycle(0, 0, 0, 8'h00);
        // End-of-frame rule computed from the collected pixel list
        if (y_seen.size() == 0) begin
            m_min = 8'hFF;
            m_max = 8'h00;
        end else begin
            int lo = 255, hi = 0;
            foreach (y_seen[i]) begin
                if (int'(y_seen[i]) < lo) lo = int'(y_seen[i]);
                if (int'(y_seen[i]) > hi) hi = int'(y_seen[i]);
            end
            m_min = 8'(lo);
            m_max = 8'(hi);
            if (hi - lo >= MIN_CON) m_thr = 8'((lo + hi + 1) / 2);
        end
        for (int i = 1; i < gap; i++) drive_cycle(0, 0, 0, 8'h00);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        per_img_vsync = 0; per_img_herf = 0; per_img_valid = 0; per_img_Y = 0;
        thr_sel = 0; thr_manual = 0;
        m_thr = THR_INIT; m_min = 0; m_max = 0; m_man_on = 0; m_man_val = 0;
        e1 = '{0, 0, 0, 8'h00};
        e2 = '{0, 0, 0, 8'h00};
        repeat (3) @(negedge clk);
        checks++;
        if ({post_img_vsync, post_img_herf, post_img_valid, post_img_bin, frame_thr, frame_min, frame_max}
            !== {3'b000, 8'h00, THR_INIT, 8'h00, 8'h00}) begin
            errors++;
            $display("FAIL reset_state got %b%b%b bin%h thr%0d min%0d max%0d", post_img_vsync,
                     post_img_herf, post_img_valid, post_img_bin, frame_thr, frame_min, frame_max);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_ramp();
        for (int pass = 0; pass < 2; pass++) begin
            pix_q.delete();
            for (int i = 0; i < 16; i++) pix_q.push_back(8'(i * 16));
            play_frame(4, pass == 1, 4);
            checks++;
            if ({frame_thr, frame_min, frame_max} !== {8'd120, 8'd0, 8'd240}) begin
                errors++;
                $display("FAIL ramp_%0d got thr%0d min%0d max%0d want 120 0 240", pass,
                         frame_thr, frame_min, frame_max);
            end
        end
    endtask

    task automatic test_flat();
        logic [7:0] thr_before;
        thr_before = frame_thr;
        pix_q.delete();
        repeat (12) pix_q.push_back(8'd50);
        play_frame(4, 1, 4);
        checks++;
        if ({frame_thr, frame_min, frame_max} !== {thr_before, 8'd50, 8'd50}) begin
            errors++;
            $display("FAIL flat got thr%0d min%0d max%0d want %0d 50 50", frame_thr, frame_min,
                     frame_max, thr_before);
        end
    endtask

    task automatic test_two_level();
        pix_q.delete();
        pix_q.push_back(8'd10);
        pix_q.push_back(8'd200);
        repeat (10) pix_q.push_back($urandom_range(0, 1) ? 8'd200 : 8'd10);
        play_frame(3, 1, 4);
        checks++;
        if ({frame_thr, frame_min, frame_max} !== {8'd105, 8'd10, 8'd200}) begin
            errors++;
            $display("FAIL two_level got thr%0d min%0d max%0d want 105 10 200", frame_thr,
                     frame_min, frame_max);
        end
    endtask

    task automatic test_contrast_boundary();
        // Contrast 15 must hold the threshold, 16 must update it to 108.
        for (int d = 15; d <= 16; d++) begin
            logic [7:0] want;
            want = (d >= MIN_CON) ? 8'd108 : frame_thr;
            pix_q.delete();
            pix_q.push_back(8'd100);
            pix_q.push_back(8'(100 + d));
            repeat (4) pix_q.push_back(8'($urandom_range(100, 100 + d)));
            play_frame(2, 0, 4);
            checks++;
            if ({frame_thr, frame_min, frame_max} !== {want, 8'd100, 8'(100 + d)}) begin
                errors++;
                $display("FAIL contrast_%0d got thr%0d min%0d max%0d want thr%0d", d, frame_thr,
                         frame_min, frame_max, want);
            end
        end
    endtask

    task automatic test_empty_frame();
        logic [7:0] thr_before;
        thr_before = frame_thr;
        pix_q.delete();
        play_frame(4, 0, 4);
        checks++;
        if ({frame_thr, frame_min, frame_max} !== {thr_before, 8'hFF, 8'h00}) begin
            errors++;
            $display("FAIL empty got thr%0d min%h max%h want %0d FF 00", frame_thr, frame_min,
                     frame_max, thr_before);
        end
    endtask

    task automatic test_offframe_pixels();
        // Valid pixels with vsync low are binarized but excluded from stats.
        drive_cycle(0, 1, 1, 8'd0);
        drive_cycle(0, 1, 1, 8'd255);
        drive_cycle(0, 0, 0, 8'd0);
        pix_q.delete();
        repeat (8) pix_q.push_back(8'($urandom_range(60, 90)));
        play_frame(4, 1, 4);
        checks++;
        if ({frame_thr, frame_min, frame_max} !== {m_thr, m_min, m_max}) begin
            errors++;
            $display("FAIL offframe got thr%0d min%0d max%0d want %0d %0d %0d", frame_thr,
                     frame_min, frame_max, m_thr, m_min, m_max);
        end
    endtask

    task automatic test_random_frames();
        for (int f = 0; f < 6; f++) begin
            int lo, hi, n;
            lo = $urandom_range(0, 255);
            hi = $urandom_range(lo, 255);
            n  = $urandom_range(6, 30);
            pix_q.delete();
            repeat (n) pix_q.push_back(8'($urandom_range(lo, hi)));
            play_frame($urandom_range(3, 6), 1, 4);
            checks++;
            if ({frame_thr, frame_min, frame_max} !== {m_thr, m_min, m_max}) begin
                errors++;
                $display("FAIL random_%0d got thr%0d min%0d max%0d want %0d %0d %0d", f,
                         frame_thr, frame_min, frame_max, m_thr, m_min, m_max);
            end
        end
    endtask

    task automatic test_back_to_back();
        // vsync low for a single cycle: the next rise lands on the UPDATE cycle.
        pix_q.delete();
        pix_q.push_back(8'd20);
        pix_q.push_back(8'd180);
        play_frame(2, 0, 1);
        pix_q.delete();
        pix_q.push_back(8'd70);
        pix_q.push_back(8'd90);
        repeat (4) pix_q.push_back(8'($urandom_range(70, 90)));
        play_frame(3, 1, 4);
        checks++;
        if ({frame_thr, frame_min, frame_max} !== {8'd80, 8'd70, 8'd90}) begin
            errors++;
            $display("FAIL back_to_back got thr%0d min%0d max%0d want 80 70 90", frame_thr,
                     frame_min, frame_max);
        end
    endtask

    task automatic test_reset_midframe();
        drive_cycle(1, 0, 0, 8'h00);
        drive_cycle(1, 0, 0, 8'h00);
        drive_cycle(1, 1, 1, 8'd5);
        drive_cycle(1, 1, 1, 8'd250);
        drive_cycle(1, 0, 0, 8'h00);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({post_img_vsync, post_img_herf, post_img_valid, post_img_bin, frame_thr, frame_min, frame_max}
            !== {3'b000, 8'h00, THR_INIT, 8'h00, 8'h00}) begin
            errors++;
            $display("FAIL midframe_reset got %b%b%b bin%h thr%0d min%0d max%0d", post_img_vsync,
                     post_img_herf, post_img_valid, post_img_bin, frame_thr, frame_min, frame_max);
        end
        m_thr = THR_INIT; m_min = 0; m_max = 0; m_man_on = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        e2 = '{0, 0, 0, 8'h00};
        e1 = '{1, 0, 0, 8'h00};
        // Rest of the interrupted frame must not produce statistics.
        for (int i = 0; i < 6; i++) drive_cycle(1, 1, 1, 8'($urandom));
        repeat (4) drive_cycle(0, 0, 0, 8'h00);
        checks++;
        if ({frame_thr, frame_min, frame_max} !== {THR_INIT, 8'd0, 8'd0}) begin
            errors++;
            $display("FAIL partial_frame got thr%0d min%0d max%0d want 128 0 0", frame_thr,
                     frame_min, frame_max);
        end
        pix_q.delete();
        for (int i = 0; i < 16; i++) pix_q.push_back(8'(i * 16));
        play_frame(4, 0, 4);
        checks++;
        if ({frame_thr, frame_min, frame_max} !== {8'd120, 8'd0, 8'd240}) begin
            errors++;
            $display("FAIL clean_after_reset got thr%0d min%0d max%0d want 120 0 240", frame_thr,
                     frame_min, frame_max);
        end
    endtask

`ifdef BIN_MANUAL_THR_EN
    task automatic test_manual_thr();
        thr_sel    = 1'b1;
        thr_manual = 8'd60;
        pix_q.delete();
        pix_q.push_back(8'd59);
        pix_q.push_back(8'd60);
        repeat (6) pix_q.push_back($urandom_range(0, 1) ? 8'd60 : 8'd59);
        fork
            play_frame(4, 0, 4);
            begin
                repeat (6) @(posedge clk);
                #2;
                thr_sel    = 1'b0;
                thr_manual = 8'd200;
            end
        join
        checks++;
        if ({frame_thr, frame_min, frame_max} !== {8'd60, 8'd59, 8'd60}) begin
            errors++;
            $display("FAIL manual got thr%0d min%0d max%0d want 60 59 60", frame_thr, frame_min,
                     frame_max);
        end
        pix_q.delete();
        repeat (5) pix_q.push_back(8'($urandom));
        play_frame(4, 1, 4);
        checks++;
        if ({frame_thr, frame_min, frame_max} !== {m_thr, m_min, m_max}) begin
            errors++;
            $display("FAIL manual_off got thr%0d min%0d max%0d want %0d %0d %0d", frame_thr,
                     frame_min, frame_max, m_thr, m_min, m_max);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_ramp();
        test_flat();
        test_two_level();
        test_contrast_boundary();
        test_empty_frame();
        test_offframe_pixels();
        test_random_frames();
        test_back_to_back();
        test_reset_midframe();
`ifdef BIN_MANUAL_THR_EN
        test_manual_thr();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
